// File: rtl/axi_lite_word_buffer_pkg.sv
// Shared types, response codes and address decode helper for the AXI4-Lite word buffer.
package axi_lite_word_buffer_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR_HELD,
        W_DATA_HELD,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Full (unaliased) word index; callers decide between range check and modulo.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr, input int unsigned byte_lsb);
        return addr >> byte_lsb;
    endfunction

endpackage

// File: rtl/axi_lite_word_buffer_mem.sv
// Word storage: byte-enable AXI write port, full-word hw write port that yields to AXI, registered read.
module axi_lite_word_buffer_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 16,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8,
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  axi_wr_en,
    input  logic [IDX_W-1:0]      axi_wr_idx,
    input  logic [DATA_WIDTH-1:0] axi_wr_data,
    input  logic [STRB_W-1:0]     axi_wr_strb,
    input  logic                  hw_wr_en,
    input  logic [IDX_W-1:0]      hw_wr_idx,
    input  logic [DATA_WIDTH-1:0] hw_wr_data,
    output logic                  hw_wr_ack_c,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic                  rd_zero,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] words [NUM_WORDS];
    logic [DATA_WIDTH-1:0] axi_merged_c;

    // An AXI commit to the same word wins; the producer must retry.
    assign hw_wr_ack_c = rst_n && hw_wr_en && !(axi_wr_en && (axi_wr_idx == hw_wr_idx));

    always_comb begin
        axi_merged_c = words[axi_wr_idx];
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (axi_wr_strb[b]) begin
                axi_merged_c[8*b +: 8] = axi_wr_data[8*b +: 8];
            end
        end
    end

    // Read samples the pre-edge contents, so a same-cycle write is seen only by later reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words   <= '{default: '0};
            rd_data <= '0;
        end else begin
            if (hw_wr_ack_c) begin
                words[hw_wr_idx] <= hw_wr_data;
            end
            if (axi_wr_en) begin
                words[axi_wr_idx] <= axi_merged_c;
            end
            if (rd_en) begin
                rd_data <= rd_zero ? '0 : words[rd_idx];
            end
        end
    end

endmodule

// File: rtl/axi_lite_word_buffer.sv
// AXI4-Lite slave word buffer with an on-chip producer write port.
// Define AXI_BUF_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module axi_lite_word_buffer
    import axi_lite_word_buffer_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_WORDS        = 16,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              hw_wr_en,
    input  logic [$clog2(C_NUM_WORDS)-1:0]    hw_wr_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     hw_wr_data,
    output logic                              hw_wr_ack
);

    localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned BYTE_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(C_NUM_WORDS);

    logic [31:0]      aw_word_c, ar_word_c;
    logic [IDX_W-1:0] aw_idx_c, ar_idx_c;
    logic             aw_err_c, ar_err_c;
    logic             unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};
    assign aw_word_c   = addr_to_idx(32'(S_AXI_AWADDR), BYTE_LSB);
    assign ar_word_c   = addr_to_idx(32'(S_AXI_ARADDR), BYTE_LSB);

`ifdef AXI_BUF_ERR_RESP_EN
    assign aw_err_c = aw_word_c >= 32'(C_NUM_WORDS);
    assign ar_err_c = ar_word_c >= 32'(C_NUM_WORDS);
    assign aw_idx_c = IDX_W'(aw_word_c);
    assign ar_idx_c = IDX_W'(ar_word_c);
`else
    assign aw_err_c = 1'b0;
    assign ar_err_c = 1'b0;
    assign aw_idx_c = IDX_W'(aw_word_c % 32'(C_NUM_WORDS));
    assign ar_idx_c = IDX_W'(ar_word_c % 32'(C_NUM_WORDS));
`endif

    // ---------------- write channel ----------------
    w_state_t                  w_state, w_state_d;
    logic                      aw_ready, w_ready, bvalid;
    logic                      aw_ready_d, w_ready_d, bvalid_d;
    logic [1:0]                bresp;
    logic [IDX_W-1:0]          aw_idx_q;
    logic                      aw_err_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic                      aw_hs_c, w_hs_c, commit_c;
    logic [IDX_W-1:0]          cm_idx_c;
    logic                      cm_err_c;
    logic [C_S_AXI_DATA_WIDTH-1:0] cm_data_c;
    logic [STRB_W-1:0]         cm_strb_c;

    assign aw_hs_c   = S_AXI_AWVALID && aw_ready;
    assign w_hs_c    = S_AXI_WVALID && w_ready;
    // Commit uses the live channel for whichever half arrives in the commit cycle.
    assign cm_idx_c  = aw_hs_c ? aw_idx_c : aw_idx_q;
    assign cm_err_c  = aw_hs_c ? aw_err_c : aw_err_q;
    assign cm_data_c = w_hs_c ? S_AXI_WDATA : wdata_q;
    assign cm_strb_c = w_hs_c ? S_AXI_WSTRB : wstrb_q;

    always_comb begin
        w_state_d = w_state;
        commit_c  = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c  = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs_c) begin
                    w_state_d = W_ADDR_HELD;
                end else if (w_hs_c) begin
                    w_state_d = W_DATA_HELD;
                end
            end
            W_ADDR_HELD: begin
                if (w_hs_c) begin
                    commit_c  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_DATA_HELD: begin
                if (aw_hs_c) begin
                    commit_c  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        aw_ready_d = (w_state_d == W_IDLE) || (w_state_d == W_DATA_HELD);
        w_ready_d  = (w_state_d == W_IDLE) || (w_state_d == W_ADDR_HELD);
        bvalid_d   = (w_state_d == W_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            aw_idx_q <= '0;
            aw_err_q <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            w_state  <= w_state_d;
            aw_ready <= aw_ready_d;
            w_ready  <= w_ready_d;
            bvalid   <= bvalid_d;
            if (aw_hs_c) begin
                aw_idx_q <= aw_idx_c;
                aw_err_q <= aw_err_c;
            end
            if (w_hs_c) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit_c) begin
                bresp <= cm_err_c ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t   r_state, r_state_d;
    logic       ar_ready, rvalid, ar_ready_d, rvalid_d;
    logic [1:0] rresp;
    logic       ar_hs_c;

    assign ar_hs_c = S_AXI_ARVALID && ar_ready;

    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs_c) r_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        ar_ready_d = (r_state_d == R_IDLE);
        rvalid_d   = (r_state_d == R_DATA);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state  <= R_IDLE;
            ar_ready <= 1'b0;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
        end else begin
            r_state  <= r_state_d;
            ar_ready <= ar_ready_d;
            rvalid   <= rvalid_d;
            if (ar_hs_c) begin
                rresp <= ar_err_c ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    axi_lite_word_buffer_mem #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
        .NUM_WORDS  (C_NUM_WORDS)
    ) u_mem (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .axi_wr_en   (commit_c && !cm_err_c),
        .axi_wr_idx  (cm_idx_c),
        .axi_wr_data (cm_data_c),
        .axi_wr_strb (cm_strb_c),
        .hw_wr_en    (hw_wr_en),
        .hw_wr_idx   (hw_wr_idx),
        .hw_wr_data  (hw_wr_data),
        .hw_wr_ack_c (hw_wr_ack),
        .rd_en       (ar_hs_c),
        .rd_idx      (ar_idx_c),
        .rd_zero     (ar_err_c),
        .rd_data     (S_AXI_RDATA)
    );

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;

endmodule

// File: tb/tb_axi_lite_word_buffer.sv
// Scoreboard bench for axi_lite_word_buffer: directed scenarios plus randomized traffic against an array model.
module tb_axi_lite_word_buffer;

    localparam int NW = 16;
`ifdef AXI_BUF_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [7:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [7:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        hw_wr_en;
    logic [3:0]  hw_wr_idx;
    logic [31:0] hw_wr_data;
    logic        hw_wr_ack;

    axi_lite_word_buffer dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .hw_wr_en(hw_wr_en), .hw_wr_idx(hw_wr_idx), .hw_wr_data(hw_wr_data), .hw_wr_ack(hw_wr_ack)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [31:0] model [NW];
    logic [1:0]  b_q [$];
    rexp_t       r_q [$];
    logic [1:0]  mon_b;
    rexp_t       mon_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    // Reference rules: word = addr/4; out of range either errors or wraps modulo depth.
    function automatic bit addr_err(input logic [7:0] a);
        return ERR_EN && ((int'(a) / 4) >= NW);
    endfunction

    function automatic int word_of(input logic [7:0] a);
        return (int'(a) / 4) % NW;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!addr_err(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[word_of(a)][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    function automatic rexp_t exp_read(input logic [7:0] a);
        rexp_t e;
        if (addr_err(a)) begin
            e.data = 32'h0;
            e.resp = SLVERR;
        end else begin
            e.data = model[word_of(a)];
            e.resp = OKAY;
        end
        return e;
    endfunction

    // Monitor: every completed B/R handshake is matched against the oldest expectation.
    always @(negedge ACLK) begin
        if (ARESETN && S_AXI_BVALID && S_AXI_BREADY) begin
            if (b_q.size() == 0) begin
                flag("b_unexpected");
            end else begin
                mon_b = b_q.pop_front();
                chk("bresp", 64'(S_AXI_BRESP), 64'(mon_b));
            end
        end
        if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
            if (r_q.size() == 0) begin
                flag("r_unexpected");
            end else begin
                mon_r = r_q.pop_front();
                chk("rdata", 64'(S_AXI_RDATA), 64'(mon_r.data));
                chk("rresp", 64'(S_AXI_RRESP), 64'(mon_r.resp));
            end
        end
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        int aw_hs, w_hs, bv, later;
        aw_hs = -1;
        w_hs  = -1;
        bv    = -1;
        b_q.push_back(addr_err(a) ? SLVERR : OKAY);
        model_write(a, d, s);
        fork
            begin
                repeat (aw_dly) begin @(posedge ACLK); #1; end
                S_AXI_AWADDR  = a;
                S_AXI_AWVALID = 1'b1;
                for (int n = 0; n < 50; n++) begin
                    @(negedge ACLK);
                    if (S_AXI_AWREADY) begin aw_hs = cyc; break; end
                end
                @(posedge ACLK); #1;
                S_AXI_AWVALID = 1'b0;
            end
            begin
                repeat (w_dly) begin @(posedge ACLK); #1; end
                S_AXI_WDATA  = d;
                S_AXI_WSTRB  = s;
                S_AXI_WVALID = 1'b1;
                for (int n = 0; n < 50; n++) begin
                    @(negedge ACLK);
                    if (S_AXI_WREADY) begin w_hs = cyc; break; end
                end
                @(posedge ACLK); #1;
                S_AXI_WVALID = 1'b0;
            end
        join
        if (aw_hs < 0 || w_hs < 0) flag("aw_w_handshake_timeout");
        later = (aw_hs > w_hs) ? aw_hs : w_hs;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin bv = cyc; break; end
        end
        if (bv < 0) flag("bvalid_timeout");
        else chk("b_latency", 64'(bv), 64'(later + 1));
        repeat (b_dly) begin
            @(negedge ACLK);
            chk("bvalid_hold", 64'(S_AXI_BVALID), 64'(1));
        end
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, input int r_dly);
        int ar_hs, rv;
        rexp_t e;
        ar_hs = -1;
        rv    = -1;
        e = exp_read(a);
        r_q.push_back(e);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin ar_hs = cyc; break; end
        end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        if (ar_hs < 0) flag("ar_handshake_timeout");
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin rv = cyc; break; end
        end
        if (rv < 0) flag("rvalid_timeout");
        else chk("r_latency", 64'(rv), 64'(ar_hs + 1));
        repeat (r_dly) begin
            @(negedge ACLK);
            chk("rvalid_hold", 64'(S_AXI_RVALID), 64'(1));
            chk("rdata_hold", 64'(S_AXI_RDATA), 64'(e.data));
        end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic hw_write(input logic [3:0] idx, input logic [31:0] d);
        hw_wr_en   = 1'b1;
        hw_wr_idx  = idx;
        hw_wr_data = d;
        @(negedge ACLK);
        chk("hw_ack_idle", 64'(hw_wr_ack), 64'(1));
        model[idx] = d;
        @(posedge ACLK); #1;
        hw_wr_en = 1'b0;
    endtask

    initial begin
        repeat (30000) @(posedge ACLK);
        $display("FAIL watchdog: simulation did not complete in cycle budget");
        $fatal(1);
    end

    int op, d1, d2, d3;
    logic [7:0] ra;

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        hw_wr_en = 1'b1; hw_wr_idx = 4'd1; hw_wr_data = 32'hFFFF_FFFF;
        for (int i = 0; i < NW; i++) model[i] = 32'h0;

        // Reset state, with a pending hw request that must not be acked
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", 64'(S_AXI_AWREADY), 64'(0));
        chk("rst_wready",  64'(S_AXI_WREADY),  64'(0));
        chk("rst_arready", 64'(S_AXI_ARREADY), 64'(0));
        chk("rst_bvalid",  64'(S_AXI_BVALID),  64'(0));
        chk("rst_rvalid",  64'(S_AXI_RVALID),  64'(0));
        chk("rst_bresp",   64'(S_AXI_BRESP),   64'(0));
        chk("rst_rresp",   64'(S_AXI_RRESP),   64'(0));
        chk("rst_rdata",   64'(S_AXI_RDATA),   64'(0));
        chk("rst_hw_ack",  64'(hw_wr_ack),     64'(0));
        @(posedge ACLK); #1;
        hw_wr_en = 1'b0;
        ARESETN  = 1'b1;
        @(posedge ACLK); #1;

        // Sequential write then readback
        for (int i = 0; i < 4; i++) axi_write(8'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(8'(4 * i), 0);

        // Byte strobes
        axi_write(8'h10, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
        axi_write(8'h10, 32'h1122_3344, 4'b0101, 0, 0, 0);
        axi_read(8'h10, 1);
        axi_write(8'h1C, 32'h0BAD_F00D, 4'h0, 0, 0, 0);
        axi_read(8'h1C, 0);

        // Channel ordering with BREADY stalled
        axi_write(8'h14, 32'h5555_0001, 4'hF, 3, 0, 4);
        axi_write(8'h18, 32'h6666_0002, 4'hF, 0, 2, 4);
        axi_read(8'h14, 2);
        axi_read(8'h18, 0);

        // Same-index collision: AXI wins, hw retries next cycle; concurrent AR sees pre-hw value
        b_q.push_back(OKAY);
        model[2] = 32'h5;
        S_AXI_AWADDR = 8'h08; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h5;  S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        hw_wr_en = 1'b1; hw_wr_idx = 4'd2; hw_wr_data = 32'h9;
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        chk("coll_awready", 64'(S_AXI_AWREADY), 64'(1));
        chk("coll_wready",  64'(S_AXI_WREADY),  64'(1));
        chk("coll_hw_ack",  64'(hw_wr_ack),     64'(0));
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        r_q.push_back('{data: 32'h5, resp: OKAY});
        S_AXI_ARADDR = 8'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        chk("retry_hw_ack",  64'(hw_wr_ack),     64'(1));
        chk("retry_arready", 64'(S_AXI_ARREADY), 64'(1));
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0; hw_wr_en = 1'b0;
        model[2] = 32'h9;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(8'h08, 0);

        // Different-index AXI commit and hw write in the same cycle
        b_q.push_back(OKAY);
        model[3] = 32'h3333_3333;
        model[4] = 32'h4444_4444;
        S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h3333_3333; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        hw_wr_en = 1'b1; hw_wr_idx = 4'd4; hw_wr_data = 32'h4444_4444;
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        chk("diff_hw_ack", 64'(hw_wr_ack), 64'(1));
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; hw_wr_en = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        axi_read(8'h0C, 0);
        axi_read(8'h10, 0);

        // Out of range (SLVERR or alias onto word 0)
        axi_write(8'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(8'h40, 0);
        axi_read(8'h00, 0);
        axi_read(8'h43, 0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = 8'($urandom_range(0, 255));
            else ra = 8'($urandom_range(0, 63));
            d1 = int'($urandom_range(0, 3));
            d2 = int'($urandom_range(0, 3));
            d3 = int'($urandom_range(0, 3));
            case (op)
                0, 1:    axi_write(ra, $urandom, 4'($urandom_range(0, 15)), d1, d2, d3);
                2:       axi_read(ra, d1);
                default: hw_write(4'($urandom_range(0, 15)), $urandom);
            endcase
        end

        // Reset while BVALID is pending: response abandoned, buffer cleared
        S_AXI_AWADDR = 8'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        chk("prerst_awready", 64'(S_AXI_AWREADY), 64'(1));
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        chk("prerst_bvalid", 64'(S_AXI_BVALID), 64'(1));
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("midrst_bvalid",  64'(S_AXI_BVALID),  64'(0));
        chk("midrst_awready", 64'(S_AXI_AWREADY), 64'(0));
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        for (int i = 0; i < NW; i++) model[i] = 32'h0;
        @(posedge ACLK); #1;
        for (int i = 0; i < NW; i++) axi_read(8'(4 * i), 0);
        axi_write(8'h24, 32'hCAFE_0001, 4'hF, 1, 0, 1);
        axi_read(8'h24, 0);

        repeat (5) @(posedge ACLK);
        #1;
        chk("b_queue_drained", 64'(b_q.size()), 64'(0));
        chk("r_queue_drained", 64'(r_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_word_buffer.md
Name: axi_lite_word_buffer

Overview:
- Parametrised AXI4-Lite slave register buffer; successor to the fixed 4 x 32-bit buffer.
- Width, depth and byte-strobe handling are generalised.
- Adds a hardware-side write port so an on-chip producer (SCA capture logic next to VexRiscv) can deposit words that the host reads over AXI4-Lite.
- Sits behind the AXI interconnect in the block design; exercised by the master VIP bench.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- C_NUM_WORDS, 16, buffer depth in words; power of two, 4..1024.
- C_S_AXI_ADDR_WIDTH, 8, byte address width; must be >= log2(C_NUM_WORDS * C_S_AXI_DATA_WIDTH/8).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR/3/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA/DATA/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR/3/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA/2/1/1  read data channel.
- hw_wr_en  in  1  hardware write request.
- hw_wr_idx  in  log2(C_NUM_WORDS)  hardware word index.
- hw_wr_data  in  DATA  hardware write data (full word).
- hw_wr_ack  out  1  request accepted this cycle.

Behaviour:
- Reset, sampled on ACLK while ARESETN=0:
  - all READY, VALID and hw_wr_ack = 0; BRESP = RRESP = 0; RDATA = 0.
  - all buffer words = 0; both FSMs return to IDLE.
  - Reset mid-transaction abandons the transaction; no response is issued.
- Word index = addr[ADDR-1 : log2(DATA/8)]; low address bits are ignored. The index is in range if < C_NUM_WORDS.
- Write FSM, states W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP:
  - W_IDLE: AWREADY = WREADY = 1. Accept AW and W in the same cycle or separately; a channel that has been accepted holds its READY low until the other arrives.
  - Once both are held: commit the write on the next edge, then W_RESP with BVALID = 1.
  - Commit latency: 1 cycle after the later of AW/W handshakes.
  - W_RESP: hold BVALID until BREADY, then W_IDLE. No new AW/W is accepted while in W_RESP.
  - Byte lane b is written only if WSTRB[b] = 1; WSTRB = 0 leaves the word unchanged and still returns OKAY.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY = 1. On handshake, register RDATA = buffer[idx] and go to R_DATA with RVALID = 1.
  - RDATA/RRESP are held stable until RREADY; then R_IDLE.
  - Read latency: RVALID in the cycle after the AR handshake.
- Hardware port:
  - hw_wr_ack = hw_wr_en AND NOT (AXI commit to the same index this cycle).
  - On ack, buffer[hw_wr_idx] = hw_wr_data (all lanes) at the edge.
  - AXI commit to a different index and hw write proceed in the same cycle.
  - On a same-index collision AXI wins; the producer holds its request and retries.
- Read/write collision: an AR handshake in the same cycle as a commit to the same word returns the old value (read-before-write).
- AXI and hardware write beats are always 1; there are no bursts. AxPROT is ignored.

Optional Feature:
- Macro AXI_BUF_ERR_RESP_EN.
- Defined:
  - An out-of-range write is discarded with BRESP = SLVERR (2'b10).
  - An out-of-range read returns RDATA = 0 with RRESP = SLVERR.
  - An out-of-range hw_wr_idx is not acked.
- Undefined:
  - The index is taken modulo C_NUM_WORDS (aliasing) and RESP is always OKAY.
  - An out-of-range hw_wr_idx is acked and aliases likewise.

Decomposition:
- Package axi_lite_word_buffer_pkg holds:
  - enums w_state_t and r_state_t.
  - constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - function addr_to_idx.
- One sub-module, axi_lite_word_buffer_mem: the storage array with a byte-enable AXI write port, a full-word hw port with the collision-ack rule, and a registered read port.

Test Plan:
- Sequential write/readback: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read the same addresses -> the same data, all OKAY.
- Byte strobes: write 0xAABBCCDD to 0x10, then 0x11223344 with WSTRB = 4'b0101 -> read returns 0xAA22CC44.
- Channel ordering: W presented 3 cycles before AW, then AW 2 cycles before W -> one commit each; BVALID is 1 cycle after the later handshake; held for 4 cycles of BREADY = 0.
- Hardware port collision: AXI write 0x5 and hw write 0x9 to index 2 in the same cycle -> hw_wr_ack = 0, word = 0x5; hw acked next cycle -> word = 0x9.
- Out of range, with C_NUM_WORDS = 16:
  - with AXI_BUF_ERR_RESP_EN, write/read at 0x40 -> SLVERR, RDATA = 0, word 0 unchanged.
  - without the macro -> OKAY, aliases word 0.
- Reset mid-transaction: ARESETN low while BVALID = 1 -> next cycle BVALID = 0 and all words = 0; a subsequent transaction completes normally.
